// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, write-no-allocate byte cache in
// front of a fixed-latency backing memory, with saturating hit/miss counters.
module data_cache #(
    parameter int NBITS       = 8,
    parameter int NLINES      = 8,
    parameter int MEM_LATENCY = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:0] ADDR,
    input  logic [NBITS-1:0] WriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [NBITS-1:0] ReadData,
    output logic             busy,
    output logic [NBITS-1:0] hits,
    output logic [NBITS-1:0] misses
);
    localparam int IW    = $clog2(NLINES);
    localparam int TW    = NBITS - IW;
    localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int DEPTH = 1 << NBITS;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [NBITS-1:0]  r_addr, r_wdata;
    logic [NBITS-1:0]  r_hits, r_misses;
    logic [NLINES-1:0] r_valid;
    logic [TW-1:0]     r_tag  [NLINES];
    logic [NBITS-1:0]  r_line [NLINES];
    logic [NBITS-1:0]  r_mem  [DEPTH];

    logic [IW-1:0]    w_idx_in, w_wr_idx, w_fill_idx;
    logic [TW-1:0]    w_tag_in, w_wr_tag, w_fill_tag;
    logic             w_hit, w_done, w_wr_line_hit;
    logic             w_accept_wr, w_rd_hit, w_rd_miss, w_fill, w_mem_we;
    logic [NBITS-1:0] w_mem_waddr, w_mem_wdata;

    assign w_idx_in   = ADDR[IW-1:0];
    assign w_tag_in   = ADDR[NBITS-1:IW];
    assign w_fill_idx = r_addr[IW-1:0];
    assign w_fill_tag = r_addr[NBITS-1:IW];
    assign w_hit      = r_valid[w_idx_in] && (r_tag[w_idx_in] == w_tag_in);
    assign w_done     = (r_cnt == '0);

    assign w_wr_idx      = w_mem_waddr[IW-1:0];
    assign w_wr_tag      = w_mem_waddr[NBITS-1:IW];
    assign w_wr_line_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

    assign hits   = r_hits;
    assign misses = r_misses;

    // Next-state, handshake outputs and per-cycle action strobes; everything
    // is held inert while reset is high so requests during reset are ignored.
    always_comb begin
        w_next      = r_state;
        busy        = 1'b0;
        ReadData    = '0;
        w_accept_wr = 1'b0;
        w_rd_hit    = 1'b0;
        w_rd_miss   = 1'b0;
        w_fill      = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_waddr = r_addr;
        w_mem_wdata = r_wdata;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (MemWrite) begin
                        if (MEM_LATENCY == 1) begin
                            // single-cycle memory: commit straight from the inputs
                            w_mem_we    = 1'b1;
                            w_mem_waddr = ADDR;
                            w_mem_wdata = WriteData;
                        end else begin
                            busy        = 1'b1;
                            w_accept_wr = 1'b1;
                            w_next      = WRITE;
                        end
                    end else if (MemRead) begin
                        if (w_hit) begin
                            ReadData = r_line[w_idx_in];
                            w_rd_hit = 1'b1;
                        end else begin
                            busy      = 1'b1;
                            w_rd_miss = 1'b1;
                            w_next    = FILL;
                        end
                    end
                end
                FILL: begin
                    if (w_done) begin
                        ReadData = r_mem[r_addr];
                        w_fill   = 1'b1;
                        w_next   = IDLE;
                    end else begin
                        busy = 1'b1;
                    end
                end
                WRITE: begin
                    if (w_done) begin
                        w_mem_we = 1'b1;
                        w_next   = IDLE;
                    end else begin
                        busy = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Control state: FSM, latency counter, request latches, valid bits, counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_valid  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept_wr || w_rd_miss) begin
                r_addr <= ADDR;
                r_cnt  <= CNT_INIT;
            end else if ((r_state != IDLE) && !w_done) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_accept_wr)
                r_wdata <= WriteData;
            if (w_fill)
                r_valid[w_fill_idx] <= 1'b1;
            if (w_rd_hit && (r_hits != '1))
                r_hits <= r_hits + 1'b1;
            if (w_rd_miss && (r_misses != '1))
                r_misses <= r_misses + 1'b1;
        end
    end

    // Storage arrays survive reset; only the strobes above (gated by reset) move them.
    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_line[w_fill_idx] <= r_mem[r_addr];
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
            // write-through: refresh the cached copy only if this address is resident
            if (w_wr_line_hit)
                r_line[w_wr_idx] <= w_mem_wdata;
        end
    end
endmodule
